// File: rtl/crc_frame_pkg.sv
// Shared constants for the per-frame CRC engine: mode values, FSM encoding,
// default frame geometry and the common non-reflected polynomials.
package crc_frame_pkg;

    localparam logic MAP   = 1'b1;
    localparam logic DEMAP = 1'b0;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } crc_state_t;

    localparam int DEF_OH_COLS  = 16;
    localparam int DEF_CRC_COL  = 1040;
    localparam int DEF_LAST_ROW = 3;

    localparam logic [31:0] CRC8_POLY  = 32'h0000_0007;
    localparam logic [31:0] CRC16_POLY = 32'h0000_1021;
    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;

endpackage

// File: rtl/crc_frame_engine_byte_step.sv
// One byte of a non-reflected CRC: eight serial shift/XOR steps, MSB of the
// data byte first, polynomial with implicit x^CRC_W term.
module crc_byte_step #(
    parameter int          CRC_W = 8,
    parameter logic [31:0] POLY  = 32'h07
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [7:0]       data,
    output logic [CRC_W-1:0] crc_out
);

    localparam logic [CRC_W-1:0] P = POLY[CRC_W-1:0];

    logic [CRC_W-1:0] sh;

    always_comb begin
        sh = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (sh[CRC_W-1] ^ data[i]) sh = {sh[CRC_W-2:0], 1'b0} ^ P;
            else                       sh = {sh[CRC_W-2:0], 1'b0};
        end
        crc_out = sh;
    end

endmodule

// File: rtl/crc_frame_engine.sv
// Per-frame CRC generator (MAP) / checker (DEMAP) with a 1-cycle line path.
// Optional macro CRC_FRAME_ENGINE_INJECT_EN adds a one-shot CRC corruption.
module crc_frame_engine
    import crc_frame_pkg::*;
#(
    parameter int          MAP_MODE  = 1,
    parameter int          CRC_W     = 8,
    parameter logic [31:0] POLY      = CRC8_POLY,
    parameter logic [31:0] INIT      = 32'hFFFF_FFFF,
    parameter int          ROW_W     = 2,
    parameter int          COL_W     = 11,
    parameter int          OH_COLS   = DEF_OH_COLS,
    parameter int          CRC_COL   = DEF_CRC_COL,
    parameter int          ERR_CNT_W = 16
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [((ROW_W > 0) ? ROW_W : 1)-1:0] i_row_cnt,
    input  logic [COL_W-1:0]                      i_col_cnt,
    input  logic [7:0]                            i_frame_data,
    input  logic                                  i_frame_data_valid,
    input  logic                                  i_frame_data_fas,
    input  logic                                  i_crc_inject,
    input  logic                                  i_err_cnt_clr,
    output logic [7:0]                            o_frame_data,
    output logic                                  o_frame_data_valid,
    output logic                                  o_frame_data_fas,
    output logic [CRC_W-1:0]                      o_crc_val,
    output logic                                  o_crc_err,
    output logic                                  o_crc_err_valid,
    output logic [ERR_CNT_W-1:0]                  o_crc_err_cnt
);

    localparam int               CRC_BYTES = CRC_W / 8;
    localparam int               RW        = (ROW_W > 0) ? ROW_W : 1;
    localparam logic [RW-1:0]    LAST_ROW  = RW'((1 << ROW_W) - 1);
    localparam bit               IS_MAP    = (MAP_MODE == int'(MAP));
    localparam logic [CRC_W-1:0] INIT_V    = INIT[CRC_W-1:0];

    // Line handshake: i_frame_data_valid qualifies a byte; there is no
    // backpressure, and valid/fas/data all leave exactly one cycle later.
    crc_state_t       state_q, state_d;
    logic [CRC_W-1:0] acc_q, snap_q, step_in, step_out, cur_snap;
    logic [2:0]       idx_q, idx_d;
    logic             sticky_q, sticky_d;
    logic [31:0]      col32, k32;
    logic             is_sof, is_pay, is_crc, crc_first, emit_byte, cur_emit, last;
    logic             mism, err_now, err_valid_d;
    logic [7:0]       snap_byte, inj_mask, data_d;

    always_comb begin
        col32     = 32'(i_col_cnt);
        k32       = col32 - 32'(CRC_COL);
        is_sof    = i_frame_data_valid && (i_row_cnt == '0) && (col32 == 0);
        is_pay    = i_frame_data_valid && (col32 >= 32'(OH_COLS)) && (col32 < 32'(CRC_COL));
        is_crc    = i_frame_data_valid && (i_row_cnt == LAST_ROW) &&
                    (col32 >= 32'(CRC_COL)) && (k32 < 32'(CRC_BYTES));
        crc_first = is_crc && (state_q == ACCUM) && (k32 == 0);
        // Only the expected next CRC byte advances EMIT; skipped bytes stall it.
        emit_byte = is_crc && (state_q == EMIT) && (k32 == 32'(idx_q));
        cur_emit  = crc_first || emit_byte;
        last      = cur_emit && (k32 == 32'(CRC_BYTES - 1));
        cur_snap  = crc_first ? acc_q : snap_q;
        snap_byte = 8'(cur_snap >> (8 * (CRC_BYTES - 1 - int'(k32[1:0]))));
        mism      = cur_emit && (i_frame_data != snap_byte);
        err_now   = ((state_q == EMIT) && sticky_q) || mism;
        step_in   = is_sof ? INIT_V : acc_q;
    end

    crc_byte_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .crc_in  (step_in),
        .data    (i_frame_data),
        .crc_out (step_out)
    );

`ifdef CRC_FRAME_ENGINE_INJECT_EN
    logic inj_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)                      inj_q <= 1'b0;
        else if (IS_MAP && i_crc_inject) inj_q <= 1'b1;
        else if (IS_MAP && last)         inj_q <= 1'b0;
    end

    assign inj_mask = {7'b0, inj_q};
`else
    logic unused_inject;
    assign unused_inject = i_crc_inject;
    assign inj_mask      = 8'h00;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ACCUM;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (crc_first && !last) state_d = EMIT;
            EMIT:    if (is_sof || last)     state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        idx_d       = idx_q;
        sticky_d    = sticky_q;
        data_d      = i_frame_data;
        err_valid_d = !IS_MAP && last;
        if (last || ((state_q == EMIT) && is_sof)) begin
            idx_d    = '0;
            sticky_d = 1'b0;
        end else if (cur_emit) begin
            idx_d    = 3'(k32) + 3'd1;
            sticky_d = err_now;
        end
        if (IS_MAP && cur_emit) data_d = snap_byte ^ (last ? inj_mask : 8'h00);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q              <= INIT_V;
            snap_q             <= '0;
            idx_q              <= '0;
            sticky_q           <= 1'b0;
            o_frame_data       <= '0;
            o_frame_data_valid <= 1'b0;
            o_frame_data_fas   <= 1'b0;
            o_crc_val          <= INIT_V;
            o_crc_err          <= 1'b0;
            o_crc_err_valid    <= 1'b0;
            o_crc_err_cnt      <= '0;
        end else begin
            if (is_pay)      acc_q <= step_out;
            else if (is_sof) acc_q <= INIT_V;
            if (crc_first) begin
                snap_q    <= acc_q;
                o_crc_val <= acc_q;
            end
            idx_q              <= idx_d;
            sticky_q           <= sticky_d;
            o_frame_data       <= data_d;
            o_frame_data_valid <= i_frame_data_valid;
            o_frame_data_fas   <= i_frame_data_fas;
            o_crc_err_valid    <= err_valid_d;
            if (err_valid_d) o_crc_err <= err_now;
            // A clear in the same cycle as an error wins.
            if (i_err_cnt_clr)
                o_crc_err_cnt <= '0;
            else if (err_valid_d && err_now && !(&o_crc_err_cnt))
                o_crc_err_cnt <= o_crc_err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_crc_frame_engine.sv
// Bench for crc_frame_engine: small-geometry MAP/DEMAP instances plus one
// default-geometry instance, scoreboarded against reference CRC values.
module tb_crc_frame_engine;

    int checks   = 0;
    int failures = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  row = '0;
    logic [10:0] col = '0;
    logic [7:0]  din = '0;
    logic        va  = 1'b0;
    logic        vb  = 1'b0;
    logic        fas = 1'b0;
    logic        inj = 1'b0;
    logic        clr = 1'b0;

    always #5 clk = ~clk;

    logic [7:0]  m8_d, m8_crc;
    logic        m8_v, m8_f, m8_err, m8_ev;
    logic [15:0] m8_cnt;
    logic [7:0]  m16_d;
    logic [15:0] m16_crc;
    logic [7:0]  m32_d;
    logic [31:0] m32_crc;
    logic [7:0]  d8_d;
    logic        d8_err, d8_ev;
    logic [1:0]  d8_cnt;
    logic        d32_err, d32_ev;
    logic [15:0] d32_cnt;
    logic [7:0]  def_d, def_crc;
    logic        def_v;
    logic        unused_m16_v, unused_m16_f, unused_m16_err, unused_m16_ev;
    logic [15:0] unused_m16_cnt;
    logic        unused_m32_v, unused_m32_f, unused_m32_err, unused_m32_ev;
    logic [15:0] unused_m32_cnt;
    logic        unused_d8_v, unused_d8_f;
    logic [7:0]  unused_d8_crc;
    logic [7:0]  unused_d32_d;
    logic        unused_d32_v, unused_d32_f;
    logic [31:0] unused_d32_crc;
    logic        unused_def_f, unused_def_err, unused_def_ev;
    logic [15:0] unused_def_cnt;

    crc_frame_engine #(.MAP_MODE(1), .CRC_W(8), .POLY(32'h07), .INIT(32'h0), .ROW_W(0),
        .COL_W(11), .OH_COLS(2), .CRC_COL(11), .ERR_CNT_W(16)) u_m8 (
        .i_clk(clk), .i_rst(rst), .i_row_cnt(row[0]), .i_col_cnt(col), .i_frame_data(din),
        .i_frame_data_valid(va), .i_frame_data_fas(fas), .i_crc_inject(inj), .i_err_cnt_clr(clr),
        .o_frame_data(m8_d), .o_frame_data_valid(m8_v), .o_frame_data_fas(m8_f),
        .o_crc_val(m8_crc), .o_crc_err(m8_err), .o_crc_err_valid(m8_ev), .o_crc_err_cnt(m8_cnt));

    crc_frame_engine #(.MAP_MODE(1), .CRC_W(16), .POLY(32'h1021), .INIT(32'h0), .ROW_W(0),
        .COL_W(11), .OH_COLS(2), .CRC_COL(11), .ERR_CNT_W(16)) u_m16 (
        .i_clk(clk), .i_rst(rst), .i_row_cnt(row[0]), .i_col_cnt(col), .i_frame_data(din),
        .i_frame_data_valid(va), .i_frame_data_fas(fas), .i_crc_inject(inj), .i_err_cnt_clr(clr),
        .o_frame_data(m16_d), .o_frame_data_valid(unused_m16_v), .o_frame_data_fas(unused_m16_f),
        .o_crc_val(m16_crc), .o_crc_err(unused_m16_err), .o_crc_err_valid(unused_m16_ev),
        .o_crc_err_cnt(unused_m16_cnt));

    crc_frame_engine #(.MAP_MODE(1), .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
        .ROW_W(0), .COL_W(11), .OH_COLS(2), .CRC_COL(11), .ERR_CNT_W(16)) u_m32 (
        .i_clk(clk), .i_rst(rst), .i_row_cnt(row[0]), .i_col_cnt(col), .i_frame_data(din),
        .i_frame_data_valid(va), .i_frame_data_fas(fas), .i_crc_inject(inj), .i_err_cnt_clr(clr),
        .o_frame_data(m32_d), .o_frame_data_valid(unused_m32_v), .o_frame_data_fas(unused_m32_f),
        .o_crc_val(m32_crc), .o_crc_err(unused_m32_err), .o_crc_err_valid(unused_m32_ev),
        .o_crc_err_cnt(unused_m32_cnt));

    crc_frame_engine #(.MAP_MODE(0), .CRC_W(8), .POLY(32'h07), .INIT(32'h0), .ROW_W(0),
        .COL_W(11), .OH_COLS(2), .CRC_COL(11), .ERR_CNT_W(2)) u_d8 (
        .i_clk(clk), .i_rst(rst), .i_row_cnt(row[0]), .i_col_cnt(col), .i_frame_data(din),
        .i_frame_data_valid(va), .i_frame_data_fas(fas), .i_crc_inject(inj), .i_err_cnt_clr(clr),
        .o_frame_data(d8_d), .o_frame_data_valid(unused_d8_v), .o_frame_data_fas(unused_d8_f),
        .o_crc_val(unused_d8_crc), .o_crc_err(d8_err), .o_crc_err_valid(d8_ev),
        .o_crc_err_cnt(d8_cnt));

    crc_frame_engine #(.MAP_MODE(0), .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
        .ROW_W(0), .COL_W(11), .OH_COLS(2), .CRC_COL(11), .ERR_CNT_W(16)) u_d32 (
        .i_clk(clk), .i_rst(rst), .i_row_cnt(row[0]), .i_col_cnt(col), .i_frame_data(din),
        .i_frame_data_valid(va), .i_frame_data_fas(fas), .i_crc_inject(inj), .i_err_cnt_clr(clr),
        .o_frame_data(unused_d32_d), .o_frame_data_valid(unused_d32_v),
        .o_frame_data_fas(unused_d32_f), .o_crc_val(unused_d32_crc), .o_crc_err(d32_err),
        .o_crc_err_valid(d32_ev), .o_crc_err_cnt(d32_cnt));

    crc_frame_engine u_def (
        .i_clk(clk), .i_rst(rst), .i_row_cnt(row), .i_col_cnt(col), .i_frame_data(din),
        .i_frame_data_valid(vb), .i_frame_data_fas(fas), .i_crc_inject(inj), .i_err_cnt_clr(clr),
        .o_frame_data(def_d), .o_frame_data_valid(def_v), .o_frame_data_fas(unused_def_f),
        .o_crc_val(def_crc), .o_crc_err(unused_def_err), .o_crc_err_valid(unused_def_ev),
        .o_crc_err_cnt(unused_def_cnt));

    logic [7:0]  exp8_q[$];
    logic [7:0]  exp16_q[$];
    logic [7:0]  exp32_q[$];
    logic [15:0] expc_q[$];
    int          n8, n32;
    logic        e8, e32;
    logic [7:0]  d8_c11;
    logic [7:0]  mem [0:3][0:1043];

    localparam logic [31:0] CRC32_GOOD = 32'h0376_E6E7;

    // Small frame: cols 0-1 overhead, 2-10 "123456789", 11-14 carry crcw MSB first.
    function automatic logic [7:0] col_byte(input int c, input logic [31:0] crcw);
        if (c < 2)       return 8'hA0 + 8'(c);
        else if (c < 11) return 8'h31 + 8'(c - 2);
        else             return crcw[8*(14-c) +: 8];
    endfunction

    task automatic do_reset();
        rst = 1'b1; va = 1'b0; vb = 1'b0; clr = 1'b0; inj = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_col(input int c, input logic [31:0] crcw, input logic clr_now);
        row = 2'd0; col = 11'(c); din = col_byte(c, crcw);
        va = 1'b1; vb = 1'b0; clr = clr_now; fas = (c == 0);
        @(negedge clk);
        va = 1'b0; clr = 1'b0; fas = 1'b0;
        if (d8_ev)  begin n8++;  e8  = d8_err;  end
        if (d32_ev) begin n32++; e32 = d32_err; end
        if (c == 11) d8_c11 = d8_d;
    endtask

    task automatic send_small(input int ncols, input logic [31:0] crcw, input int clr_col);
        for (int c = 0; c < ncols; c++) drive_col(c, crcw, c == clr_col);
    endtask

    task automatic drive_def(input int r, input int c, input logic [7:0] d);
        row = 2'(r); col = 11'(c); din = d; vb = 1'b1; va = 1'b0; fas = (r == 0 && c == 0);
        @(negedge clk);
        vb = 1'b0; fas = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({m8_v, m8_f, m8_d} !== 10'h0) begin
            failures++; $display("FAIL reset_line got=%h exp=000", {m8_v, m8_f, m8_d});
        end
        checks++;
        if (m32_crc !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL reset_crc32 got=%h exp=ffffffff", m32_crc);
        end
        checks++;
        if (def_crc !== 8'hFF || m16_crc !== 16'h0) begin
            failures++; $display("FAIL reset_crc_val got=%h/%h exp=ff/0000", def_crc, m16_crc);
        end
        checks++;
        if ({d8_ev, d8_err, d8_cnt, d32_ev, d32_err, d32_cnt} !== 22'h0) begin
            failures++; $display("FAIL reset_err got=%b%b%h %b%b%h exp=0", d8_ev, d8_err, d8_cnt,
                                 d32_ev, d32_err, d32_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_map_insert();
        logic [7:0] base, e, got;
        do_reset();
        for (int c = 0; c < 15; c++) begin
            base = col_byte(c, 32'h0);
            exp8_q.push_back(c == 11 ? 8'hF4 : base);
            exp16_q.push_back(c == 11 ? 8'h31 : (c == 12 ? 8'hC3 : base));
            exp32_q.push_back(c >= 11 ? CRC32_GOOD[8*(14-c) +: 8] : base);
            drive_col(c, 32'h0, 1'b0);
            checks++;
            if (m8_v !== 1'b1 || m8_f !== (c == 0)) begin
                failures++; $display("FAIL map_latency col=%0d got=%b%b exp=1%b", c, m8_v, m8_f, c == 0);
            end
            e = exp8_q.pop_front(); got = m8_d; checks++;
            if (got !== e) begin failures++; $display("FAIL map8_byte col=%0d got=%h exp=%h", c, got, e); end
            e = exp16_q.pop_front(); got = m16_d; checks++;
            if (got !== e) begin failures++; $display("FAIL map16_byte col=%0d got=%h exp=%h", c, got, e); end
            e = exp32_q.pop_front(); got = m32_d; checks++;
            if (got !== e) begin failures++; $display("FAIL map32_byte col=%0d got=%h exp=%h", c, got, e); end
        end
        @(negedge clk);
        checks++;
        if (m8_v !== 1'b0) begin failures++; $display("FAIL map_valid_drop got=%b exp=0", m8_v); end
        checks++;
        if ({m8_crc, m16_crc, m32_crc} !== {8'hF4, 16'h31C3, CRC32_GOOD}) begin
            failures++; $display("FAIL map_crc_val got=%h %h %h exp=f4 31c3 0376e6e7", m8_crc, m16_crc, m32_crc);
        end
        checks++;
        if ({m8_err, m8_ev, m8_cnt} !== 18'h0) begin
            failures++; $display("FAIL map_err_held got=%b%b%h exp=0", m8_err, m8_ev, m8_cnt);
        end
    endtask

    task automatic test_demap_check();
        logic [15:0] ec;
        do_reset();
        n8 = 0; send_small(15, 32'hF400_0000, -1);
        checks++;
        if (n8 !== 1 || e8 !== 1'b0 || d8_cnt !== 2'd0) begin
            failures++; $display("FAIL demap_good got=n%0d e%b c%0d exp=n1 e0 c0", n8, e8, d8_cnt);
        end
        n8 = 0; send_small(15, 32'hF500_0000, -1);
        checks++;
        if (n8 !== 1 || e8 !== 1'b1 || d8_cnt !== 2'd1 || d8_c11 !== 8'hF5) begin
            failures++; $display("FAIL demap_bad got=n%0d e%b c%0d d%h exp=n1 e1 c1 df5", n8, e8, d8_cnt, d8_c11);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (d8_err !== 1'b1 || d8_ev !== 1'b0) begin
            failures++; $display("FAIL demap_hold got=%b%b exp=10", d8_err, d8_ev);
        end
        for (int i = 2; i <= 5; i++) begin
            expc_q.push_back(16'(i > 3 ? 3 : i));
            send_small(15, 32'hF500_0000, -1);
            ec = expc_q.pop_front(); checks++;
            if (16'(d8_cnt) !== ec) begin
                failures++; $display("FAIL demap_sat frame=%0d got=%0d exp=%0d", i, d8_cnt, ec);
            end
        end
        n8 = 0; send_small(15, 32'hF500_0000, 11);
        checks++;
        if (d8_cnt !== 2'd0 || e8 !== 1'b1 || n8 !== 1) begin
            failures++; $display("FAIL demap_clr got=c%0d e%b n%0d exp=c0 e1 n1", d8_cnt, e8, n8);
        end
        n8 = 0; send_small(15, 32'hF400_0000, -1);
        checks++;
        if (d8_err !== 1'b0 || e8 !== 1'b0 || d8_cnt !== 2'd0) begin
            failures++; $display("FAIL demap_recover got=e%b c%0d exp=e0 c0", d8_err, d8_cnt);
        end
    endtask

    task automatic test_abort();
        do_reset();
        n32 = 0;
        send_small(13, CRC32_GOOD, -1);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        drive_col(13, CRC32_GOOD, 1'b0);
        drive_col(14, CRC32_GOOD, 1'b0);
        checks++;
        if (n32 !== 0) begin failures++; $display("FAIL abort_reset pulses got=%0d exp=0", n32); end
        send_small(15, CRC32_GOOD, -1);
        checks++;
        if (n32 !== 1 || e32 !== 1'b0) begin
            failures++; $display("FAIL abort_reset_next got=n%0d e%b exp=n1 e0", n32, e32);
        end
        n32 = 0;
        send_small(13, 32'h0, -1);
        checks++;
        if (n32 !== 0) begin failures++; $display("FAIL abort_sof pulses got=%0d exp=0", n32); end
        send_small(15, CRC32_GOOD, -1);
        checks++;
        if (n32 !== 1 || e32 !== 1'b0 || d32_cnt !== 16'd0) begin
            failures++; $display("FAIL abort_sof_next got=n%0d e%b c%0d exp=n1 e0 c0", n32, e32, d32_cnt);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] ref_crc, e, got;
        logic [7:0] run_crc [2];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 1044; c++) mem[r][c] = 8'($urandom);
        ref_crc = 8'hFF;
        for (int r = 0; r < 4; r++)
            for (int c = 16; c < 1040; c++) begin
                ref_crc = ref_crc ^ mem[r][c];
                for (int b = 0; b < 8; b++)
                    ref_crc = ref_crc[7] ? ((ref_crc << 1) ^ 8'h07) : (ref_crc << 1);
            end
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 1044; c++) begin
                    if (pass == 1 && ((c == 0 && r > 0) || $urandom_range(0, 3) == 0)) begin
                        repeat ($urandom_range(1, 3)) begin
                            row = 2'($urandom); col = 11'($urandom); din = 8'($urandom); vb = 1'b0;
                            @(negedge clk);
                            checks++;
                            if (def_v !== 1'b0) begin failures++; $display("FAIL gap_valid got=%b exp=0", def_v); end
                        end
                    end
                    exp8_q.push_back((r == 3 && c == 1040) ? ref_crc : mem[r][c]);
                    drive_def(r, c, mem[r][c]);
                    e = exp8_q.pop_front(); got = def_d; checks++;
                    if (def_v !== 1'b1 || got !== e) begin
                        failures++;
                        $display("FAIL def_byte pass=%0d r=%0d c=%0d got=%b/%h exp=1/%h", pass, r, c, def_v, got, e);
                    end
                end
            @(negedge clk);
            run_crc[pass] = def_crc;
            checks++;
            if (def_crc !== ref_crc) begin
                failures++; $display("FAIL def_crc_val pass=%0d got=%h exp=%h", pass, def_crc, ref_crc);
            end
        end
        checks++;
        if (run_crc[1] !== run_crc[0]) begin
            failures++; $display("FAIL gap_vs_nogap got=%h exp=%h", run_crc[1], run_crc[0]);
        end
    endtask

    task automatic test_inject();
        logic [7:0] e, got;
        do_reset();
        inj = 1'b1; @(negedge clk); inj = 1'b0;
`ifdef CRC_FRAME_ENGINE_INJECT_EN
        exp8_q.push_back(8'hF5); exp32_q.push_back(8'hE6);
`else
        exp8_q.push_back(8'hF4); exp32_q.push_back(8'hE7);
`endif
        exp8_q.push_back(8'hF4); exp32_q.push_back(8'hE7);
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < 15; c++) begin
                drive_col(c, 32'h0, 1'b0);
                if (c == 11) begin
                    e = exp8_q.pop_front(); got = m8_d; checks++;
                    if (got !== e) begin failures++; $display("FAIL inject8 frame=%0d got=%h exp=%h", f, got, e); end
                end
                if (c == 14) begin
                    e = exp32_q.pop_front(); got = m32_d; checks++;
                    if (got !== e) begin failures++; $display("FAIL inject32 frame=%0d got=%h exp=%h", f, got, e); end
                end
            end
        checks++;
        if (m8_crc !== 8'hF4) begin failures++; $display("FAIL inject_snapshot got=%h exp=f4", m8_crc); end
    endtask

    initial begin
        test_reset();
        test_map_insert();
        test_demap_check();
        test_abort();
        test_gaps();
        test_inject();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc_frame_engine.md
Name: crc_frame_engine

Overview:
Parametrised per-frame CRC generator/checker for the line datapath.
- Supports CRC width 8/16/32, any non-reflected polynomial and init value, and configurable frame geometry.
- MAP mode: accumulates the CRC over payload columns of all rows and overwrites the CRC columns of the last row with the result.
- DEMAP mode: recomputes the CRC, compares it to the received CRC bytes, and reports a per-frame error pulse plus a saturating error count.

Parameters:
MAP_MODE, 1, 1 = generate/insert, 0 = check.
CRC_W, 8, CRC width; legal values 8, 16, 32; CRC_BYTES = CRC_W/8.
POLY, 32'h07, polynomial, low CRC_W bits used, implicit x^CRC_W term.
INIT, 32'hFFFF_FFFF, accumulator start value, low CRC_W bits used.
ROW_W, 2, row counter width; last row = 2^ROW_W-1.
COL_W, 11, column counter width.
OH_COLS, 16, columns 0..OH_COLS-1 are overhead (never covered).
CRC_COL, 1040, first CRC column on the last row; payload = OH_COLS..CRC_COL-1 on every row.
ERR_CNT_W, 16, error counter width.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_row_cnt  in  ROW_W  row index of current byte
i_col_cnt  in  COL_W  column index of current byte
i_frame_data  in  8  line byte
i_frame_data_valid  in  1  byte qualifier
i_frame_data_fas  in  1  frame-alignment marker, passed through
i_crc_inject  in  1  MAP only: corrupt next inserted CRC (see Optional Feature)
i_err_cnt_clr  in  1  clears o_crc_err_cnt
o_frame_data  out  8  line byte out
o_frame_data_valid  out  1  registered valid
o_frame_data_fas  out  1  registered fas
o_crc_val  out  CRC_W  last completed frame CRC (snapshot)
o_crc_err  out  1  DEMAP: mismatch flag, qualified by o_crc_err_valid
o_crc_err_valid  out  1  DEMAP: one-cycle pulse per checked frame
o_crc_err_cnt  out  ERR_CNT_W  DEMAP: saturating mismatch count

Behaviour:
- Reset values:
  - all outputs 0, except o_crc_val = INIT.
  - accumulator = INIT; state = ACCUM; snapshot = 0; byte index = 0.
- Latency: exactly 1 cycle from input to all line outputs.
- Valid/fas always pass through registered. Cycles with valid=0 change no internal state.
- Byte classification (valid=1 only):
  - SOF: row 0, col 0.
  - Payload: OH_COLS <= col < CRC_COL, any row.
  - CRC byte k: last row, col = CRC_COL+k, for k < CRC_BYTES.
  - Anything else: pass-through only.
- Accumulator:
  - SOF loads INIT.
  - Each payload byte applies crc_byte_step, MSB-first, left shift.
  - No per-row reset.
- State machine:
  - ACCUM -> EMIT on CRC byte 0. Snapshot = accumulator; o_crc_val = snapshot.
  - EMIT -> ACCUM after byte CRC_BYTES-1, or on SOF (abort; no check reported).
  - Entering EMIT on CRC byte 0 while CRC_BYTES=1 returns to ACCUM the same cycle.
- MAP mode:
  - CRC byte k outputs snapshot byte (CRC_BYTES-1-k), MSB first.
  - o_crc_err, o_crc_err_valid and o_crc_err_cnt are held 0.
- DEMAP mode:
  - Data passes unmodified.
  - Compare each received CRC byte to the matching snapshot byte; OR mismatches into a sticky flag.
  - On the last CRC byte: o_crc_err_valid=1 for one cycle, o_crc_err = sticky OR final mismatch.
  - Counter increments on error; saturates at all-ones.
  - i_err_cnt_clr wins over a simultaneous increment (result 0).
  - o_crc_err holds its value until the next valid pulse.
- A frame missing CRC bytes produces no pulse.
- Reset mid-frame discards the partial CRC; checking resumes at the next SOF. Bytes before the first SOF accumulate from INIT, and their CRC is checked.

Optional Feature:
CRC_FRAME_ENGINE_INJECT_EN.
- Defined: in MAP mode, i_crc_inject sampled high arms a one-shot that inverts bit 0 of the next emitted snapshot's last CRC byte. The flag clears after use.
- Undefined: i_crc_inject is ignored and no inject logic is synthesised.
- DEMAP mode: the input has no effect either way.

Decomposition:
- Package crc_frame_pkg holds:
  - map-mode constants MAP=1, DEMAP=0
  - state encoding (ACCUM, EMIT)
  - default geometry constants (OH_COLS, CRC_COL, last row)
  - named polynomials CRC8_POLY=0x07, CRC16_POLY=0x1021, CRC32_POLY=0x04C11DB7
- Sub-module crc_byte_step: combinational, parameters CRC_W and POLY.
  - Inputs: crc_in, data[7:0]; output: crc_out.
  - Computes 8 serial shift-XOR iterations, MSB first.

Test Plan:
1. Bench geometry ROW_W=0, OH_COLS=2, CRC_COL=11, CRC_W=8, POLY=0x07, INIT=0, MAP. Payload "123456789" (0x31..0x39) -> column 11 output = 0xF4, o_crc_val=0xF4, overhead bytes unchanged, 1-cycle latency.
2. Same stimulus with CRC_W=16, POLY=0x1021, INIT=0 -> columns 11,12 = 0x31,0xC3. CRC_W=32, POLY=0x04C11DB7, INIT=0xFFFFFFFF -> 0x03,0x76,0xE6,0xE7.
3. DEMAP, CRC_W=8 geometry of scenario 1, received CRC 0xF4 -> err_valid pulse with err=0, count 0. Received 0xF5 -> err=1, count 1. Saturate with ERR_CNT_W=2 after 5 bad frames -> count 3. Assert clr together with an error -> count 0.
4. Default geometry MAP: valid deasserted for random gaps across row boundaries -> CRC identical to gap-free run. The last-row CRC covers all four rows' payload; row 0..2 column 1040 bytes pass through unmodified.
5. Reset or SOF asserted mid-EMIT in a 32-bit DEMAP frame -> no err_valid pulse; the next clean frame checks with err=0.
6. With CRC_FRAME_ENGINE_INJECT_EN, pulse i_crc_inject -> the next frame's last CRC byte has bit 0 inverted (scenario 1: 0xF5), and the following frame is correct (0xF4).
